// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed BCD seven-segment display path.
package bcd_disp_pkg;

    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_W      = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SEG_W      = 7;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_ERR = 7'h79;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high seven-segment pattern; non-BCD shows "E".
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pattern_c
);

    // Nibble lookup, invalid codes fall through to the error glyph
    always_comb begin
        pattern_c = SEG_ERR;
        case (nib)
            4'd0:    pattern_c = SEG_0;
            4'd1:    pattern_c = SEG_1;
            4'd2:    pattern_c = SEG_2;
            4'd3:    pattern_c = SEG_3;
            4'd4:    pattern_c = SEG_4;
            4'd5:    pattern_c = SEG_5;
            4'd6:    pattern_c = SEG_6;
            4'd7:    pattern_c = SEG_7;
            4'd8:    pattern_c = SEG_8;
            4'd9:    pattern_c = SEG_9;
            default: pattern_c = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Five-digit time-multiplexed seven-segment driver with guard cycle and leading-zero blanking.
module bcd_7seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned AN_ACTIVE_LOW  = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [4:0]  an
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned IDX_W = 3;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_POL  = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] AN_POL   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [BCD_W-1:0]      bcd_reg;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;

    logic [DIGIT_W-1:0]    nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;
    logic [DIGIT_W-1:0]    cur_nib;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [SEG_W-1:0]      pattern_c;
    logic [SEG_W-1:0]      seg_int;
    logic [NUM_DIGITS-1:0] an_int;
    logic [SEG_W-1:0]      seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    // Split the captured BCD word into per-digit nibbles
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib[k] = bcd_reg[k*DIGIT_W +: DIGIT_W];
        end
    end

    // A digit is blanked when it and every higher digit are zero; digit 0 always shows
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (nib[k] == '0);
            if (k != 0) begin
                blank[k] = blank_lz && zero_above;
            end
        end
    end

    // Select the nibble, blank flag and anode for the digit currently being scanned
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        an_sel    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = nib[k];
                cur_blank = blank[k];
                an_sel[k] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .nib       (cur_nib),
        .pattern_c (pattern_c)
    );

    // Slot counter / digit index advance and guarded, polarity-adjusted output values
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        idx_nxt = idx;
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end

        seg_int = SEG_OFF;
        an_int  = '0;
        if (cnt != '0) begin
            an_int = an_sel;
            if (!cur_blank) begin
                seg_int = pattern_c;
            end
        end
        seg_nxt = seg_int ^ SEG_POL;
        an_nxt  = an_int ^ AN_POL;
    end

    // State and output registers; reset wins over load and scan
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_reg <= '0;
            cnt     <= '0;
            idx     <= '0;
            seg     <= SEG_OFF ^ SEG_POL;
            an      <= AN_POL;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            if (load) begin
                bcd_reg <= bcd_in;
            end
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule
